// File: rtl/expr_alu_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// expr_alu_seq : sequenced integer operator unit, iterated DIV/MOD/POW
// Rev 1.0
// ---------------------------------------------------------------------------
module expr_alu_seq #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [3:0]   op_code,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_err,
  output logic         busy
);

  localparam int SHW = $clog2(W);
  localparam logic [W-1:0] C_WIDTH = W'(W);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_SAR = 4'd7;
  localparam logic [3:0] OP_EQ  = 4'd8;
  localparam logic [3:0] OP_LTU = 4'd9;
  localparam logic [3:0] OP_LTS = 4'd10;
  localparam logic [3:0] OP_DIV = 4'd11;
  localparam logic [3:0] OP_MOD = 4'd12;
  localparam logic [3:0] OP_POW = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_POW  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     code_q, code_d;
  logic [W-1:0]   res_q, res_d;
  logic           err_q, err_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   base_q, base_d;
  logic [W-1:0]   exp_q, exp_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic [SHW-1:0] cnt_q, cnt_d;

  // Single-cycle operators, evaluated straight from the offered operands
  logic [W-1:0]   w_alu_res;
  logic           w_alu_err;
  logic           w_big_sh;
  logic [SHW-1:0] w_shamt;

  assign w_big_sh = (op_b >= C_WIDTH);
  assign w_shamt  = op_b[SHW-1:0];

  always_comb begin
    w_alu_res = '0;
    w_alu_err = 1'b0;
    case (op_code)
      OP_ADD: w_alu_res = op_a + op_b;
      OP_SUB: w_alu_res = op_a - op_b;
      OP_AND: w_alu_res = op_a & op_b;
      OP_OR:  w_alu_res = op_a | op_b;
      OP_XOR: w_alu_res = op_a ^ op_b;
      OP_SHL: w_alu_res = w_big_sh ? '0 : (op_a << w_shamt);
      OP_SHR: w_alu_res = w_big_sh ? '0 : (op_a >> w_shamt);
      OP_SAR: w_alu_res = w_big_sh ? {W{op_a[W-1]}} : W'($signed(op_a) >>> w_shamt);
      OP_EQ:  w_alu_res = {{(W-1){1'b0}}, (op_a == op_b)};
      OP_LTU: w_alu_res = {{(W-1){1'b0}}, (op_a < op_b)};
      OP_LTS: w_alu_res = {{(W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_DIV, OP_MOD, OP_POW: w_alu_res = '0;
      default: begin
        w_alu_res = '0;
        w_alu_err = 1'b1;
      end
    endcase
  end

  // Restoring division step: shift the next dividend bit into the remainder
  logic [W:0]   w_rem_sh;
  logic         w_ge;
  logic [W-1:0] w_rem_nx;
  logic [W-1:0] w_quo_nx;

  assign w_rem_sh = {rem_q, quo_q[W-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, dvs_q});
  assign w_rem_nx = w_ge ? W'(w_rem_sh - {1'b0, dvs_q}) : w_rem_sh[W-1:0];
  assign w_quo_nx = {quo_q[W-2:0], w_ge};

  // Square-and-multiply step, products truncated to W bits
  logic [W-1:0] w_acc_mul;
  logic [W-1:0] w_base_sq;
  logic [W-1:0] w_exp_sh;

  assign w_acc_mul = acc_q * base_q;
  assign w_base_sq = base_q * base_q;
  assign w_exp_sh  = exp_q >> 1;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    res_d   = res_q;
    err_d   = err_q;
    acc_d   = acc_q;
    base_d  = base_q;
    exp_d   = exp_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          code_d = op_code;
          case (op_code)
            OP_DIV, OP_MOD: begin
              if (op_b == '0) begin
                res_d   = (op_code == OP_DIV) ? '1 : op_a;
                err_d   = 1'b1;
                state_d = S_DONE;
              end else begin
                quo_d   = op_a;
                rem_d   = '0;
                dvs_d   = op_b;
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = S_DIV;
              end
            end
            OP_POW: begin
              err_d = 1'b0;
              if (op_b == '0) begin
                res_d   = W'(1);
                state_d = S_DONE;
              end else begin
                acc_d   = W'(1);
                base_d  = op_a;
                exp_d   = op_b;
                state_d = S_POW;
              end
            end
            default: begin
              res_d   = w_alu_res;
              err_d   = w_alu_err;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_DIV: begin
        quo_d = w_quo_nx;
        rem_d = w_rem_nx;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(W - 1)) begin
          res_d   = (code_q == OP_DIV) ? w_quo_nx : w_rem_nx;
          state_d = S_DONE;
        end
      end
      S_POW: begin
        acc_d  = exp_q[0] ? w_acc_mul : acc_q;
        base_d = w_base_sq;
        exp_d  = w_exp_sh;
        if (w_exp_sh == '0) begin
          res_d   = acc_d;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      acc_q   <= '0;
      base_q  <= '0;
      exp_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      res_q   <= res_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
      exp_q   <= exp_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
    end
  end

  assign op_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign res_data  = res_q;
  assign res_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_expr_alu_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_expr_alu_seq : directed self-checking bench for expr_alu_seq
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_expr_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_code;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_err;
  logic        busy;

  int n_checks;
  int n_fails;
  int lat;
  int seen;

  expr_alu_seq #(.W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_code   (op_code),
    .op_a      (op_a),
    .op_b      (op_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one operation, then count edges until res_valid is first seen
  task automatic issue(input string tag, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, output int l);
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = c;
    op_a     = a;
    op_b     = b;
    check({tag, "_accept_ready"}, 32'(op_ready), 32'd1);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    l = 1;
    while (res_valid !== 1'b1 && l < 100) begin
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  task automatic release_res(input string tag);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check({tag, "_rel_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_rel_ready"}, 32'(op_ready), 32'd1);
  endtask

  task automatic run(input string tag, input logic [3:0] c, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_d, input logic exp_e,
                     input int exp_l);
    int l;
    issue(tag, c, a, b, l);
    check({tag, "_lat"}, 32'(l), 32'(exp_l));
    check({tag, "_data"}, res_data, exp_d);
    check({tag, "_err"}, 32'(res_err), 32'(exp_e));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_ready"}, 32'(op_ready), 32'd0);
    release_res(tag);
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    clk       = 1'b0;
    rst_n     = 1'b0;
    op_valid  = 1'b0;
    res_ready = 1'b0;
    op_code   = 4'd0;
    op_a      = 32'd0;
    op_b      = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_data", res_data, 32'd0);
    check("rst_err", 32'(res_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(op_ready), 32'd1);
    rst_n = 1'b1;

    run("add",     4'd0,  32'd42,         32'd9,          32'd51,         1'b0, 1);
    run("sub",     4'd1,  32'd42,         32'd9,          32'd33,         1'b0, 1);
    run("mod",     4'd12, 32'd42,         32'd9,          32'd6,          1'b0, 33);
    run("pow3",    4'd13, 32'd42,         32'd3,          32'd74088,      1'b0, 3);
    run("pow0",    4'd13, 32'd7,          32'd0,          32'd1,          1'b0, 1);
    run("pow40",   4'd13, 32'd2,          32'd40,         32'd0,          1'b0, 7);
    run("shr",     4'd6,  32'd12345678,   32'd9,          32'd24112,      1'b0, 1);
    run("sar",     4'd7,  32'hFFFFFFFF,   32'd9,          32'hFFFFFFFF,   1'b0, 1);
    run("shl",     4'd5,  32'd42,         32'd9,          32'd21504,      1'b0, 1);
    run("shl_big", 4'd5,  32'd1,          32'd40,         32'd0,          1'b0, 1);
    run("shr_big", 4'd6,  32'hFFFFFFFF,   32'd32,         32'd0,          1'b0, 1);
    run("sar_big", 4'd7,  32'h80000000,   32'd40,         32'hFFFFFFFF,   1'b0, 1);
    run("div0",    4'd11, 32'd42,         32'd0,          32'hFFFFFFFF,   1'b1, 1);
    run("mod0",    4'd12, 32'd42,         32'd0,          32'd42,         1'b1, 1);
    run("ill15",   4'd15, 32'd42,         32'd9,          32'd0,          1'b1, 1);
    run("ill14",   4'd14, 32'd1,          32'd1,          32'd0,          1'b1, 1);
    run("add_wrap",4'd0,  32'hFFFFFFFF,   32'd2,          32'd1,          1'b0, 1);
    run("sub_wrap",4'd1,  32'd0,          32'd1,          32'hFFFFFFFF,   1'b0, 1);
    run("and",     4'd2,  32'h0000F0F0,   32'h0000FF00,   32'h0000F000,   1'b0, 1);
    run("or",      4'd3,  32'h0000F0F0,   32'h0000FF00,   32'h0000FFF0,   1'b0, 1);
    run("xor",     4'd4,  32'h0000F0F0,   32'h0000FF00,   32'h00000FF0,   1'b0, 1);
    run("eq",      4'd8,  32'd5,          32'd5,          32'd1,          1'b0, 1);
    run("neq",     4'd8,  32'd5,          32'd6,          32'd0,          1'b0, 1);
    run("ltu",     4'd9,  32'hFFFFFFFF,   32'd1,          32'd0,          1'b0, 1);
    run("lts",     4'd10, 32'hFFFFFFFF,   32'd1,          32'd1,          1'b0, 1);
    run("div_big", 4'd11, 32'hFFFFFFFF,   32'h00000010,   32'h0FFFFFFF,   1'b0, 33);
    run("mod_big", 4'd12, 32'd1000003,    32'd1000,       32'd3,          1'b0, 33);

    // Back-pressure: hold the quotient while a competing request is offered
    issue("bp", 4'd11, 32'd42, 32'd9, lat);
    check("bp_lat", 32'(lat), 32'd33);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      op_valid = 1'b1;
      op_code  = 4'd0;
      op_a     = 32'd1;
      op_b     = 32'd1;
      check("bp_valid", 32'(res_valid), 32'd1);
      check("bp_data", res_data, 32'd4);
      check("bp_ready", 32'(op_ready), 32'd0);
    end
    op_valid = 1'b0;
    release_res("bp");
    @(posedge clk);
    #1;
    check("bp_ignored_valid", 32'(res_valid), 32'd0);
    check("bp_ignored_busy", 32'(busy), 32'd0);

    // Reset ten edges into a division
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = 4'd11;
    op_a     = 32'd42;
    op_b     = 32'd9;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mrst_valid", 32'(res_valid), 32'd0);
    check("mrst_ready", 32'(op_ready), 32'd1);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_data", res_data, 32'd0);
    check("mrst_err", 32'(res_err), 32'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (res_valid === 1'b1) seen++;
    end
    check("mrst_no_result", 32'(seen), 32'd0);
    run("post_rst_add", 4'd0, 32'd1, 32'd1, 32'd2, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/expr_alu_seq.md
# expr_alu_seq

Sequenced 32-bit integer operator unit for the elaboration-time constant evaluator. It accepts one binary operation at a time over a valid/ready handshake. Single-cycle operators complete in one cycle. Division, modulo and power are iterated over multiple cycles by an internal FSM. The result is held until the consumer accepts it. The block sits between the expression-tree walker and the parameter-binding stage, so that `a / b`, `a % b` and `a ** c` do not need wide combinational dividers or exponentiators.

## Interface
Parameters:
- `W`, default 32: operand and result width. Only 32 is verified.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous and active-low.
- `op_valid`  in  1  an operation is offered.
- `op_ready`  out  1  the unit can accept an operation.
- `op_code`  in  4  operation code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 SAR, 8 EQ, 9 LTU, 10 LTS, 11 DIV, 12 MOD, 13 POW. Codes 14 and 15 are illegal.
- `op_a`  in  W  left operand.
- `op_b`  in  W  right operand, shift amount or exponent.
- `res_valid`  out  1  a result is available.
- `res_ready`  in  1  the consumer accepts the result.
- `res_data`  out  W  result value.
- `res_err`  out  1  division by zero or illegal opcode.
- `busy`  out  1  the FSM is not in IDLE.

## Operation
- States: IDLE, DIV, POW, DONE.
- IDLE:
  - `op_ready`=1.
  - On `op_valid`, operands and opcode are latched.
- Single-cycle operations, from IDLE:
  - Codes 0–10, and illegal codes, compute the result and go to DONE.
- ADD, SUB, MUL-free logic ops: result is modulo 2^W, with the carry discarded.
- Shifts:
  - The full `op_b` is the shift amount.
  - For an amount ≥ W: SHL and SHR give 0; SAR gives W copies of `op_a[W-1]`.
- EQ, LTU, LTS: the result is zero-extended, 1 or 0.
- Illegal opcode: `res_data`=0, `res_err`=1.
- DIV and MOD:
  - If `op_b`=0, go directly to DONE: DIV gives all ones, MOD gives `op_a`, and `res_err`=1.
  - Otherwise enter DIV and run unsigned restoring division, one quotient bit per cycle, MSB first, for exactly W cycles, then go to DONE.
  - DIV returns the quotient; MOD returns the remainder.
- POW:
  - If `op_b`=0, go directly to DONE with result 1.
  - Otherwise enter POW with acc=1, base=`op_a`, e=`op_b`.
  - Each cycle: if e[0], acc←acc·base; base←base·base; e←e>>1. All products are truncated to W bits.
  - Go to DONE when the shifted e is 0.
- DONE:
  - `res_valid`=1.
  - `res_data` and `res_err` are stable.
  - On `res_ready`, go to IDLE.
- `op_ready`=0 in DIV, POW and DONE. There is no pipelining: at most one operation is in flight.

## Timing
- Reset values (`rst_n`=0 at a rising edge):
  - state=IDLE, `op_ready`=1 from the next cycle.
  - `res_valid`=0, `res_data`=0, `res_err`=0, `busy`=0.
  - All internal registers are cleared.
- Reset mid-operation aborts the operation with no result produced.
- Let N be the accept cycle (`op_valid`&&`op_ready` at edge N). `res_valid` first rises at:
  - single-cycle operations: edge N+1.
  - DIV/MOD with `op_b`≠0: N+1+W, which is N+33.
  - DIV/MOD with `op_b`=0: N+1.
  - POW: N+1+L, where L is the bit length of `op_b` (e.g. `op_b`=3 gives N+3). With `op_b`=0: N+1.
- Result release: with `res_ready` high at edge M while in DONE, `res_valid`=0 and `op_ready`=1 after M. A new operation is accepted no earlier than edge M+1.
- Back-pressure: `res_valid` stays high and `res_data` is held indefinitely while `res_ready`=0.
- Inputs: `op_valid` asserted while `op_ready`=0 is ignored. `op_code`, `op_a` and `op_b` are sampled only at the accept edge.
- `busy`=1 in every state except IDLE.

## Test plan
- ADD, SUB, MOD, single-cycle: a=42, b=9 with ADD, SUB and MOD. Expect ADD→51 at N+1; SUB→33 at N+1; MOD→6 at N+33 with `res_err`=0.
- POW: a=42, b=3 → 74088 at N+3. Then a=7, b=0 → 1 at N+1. Then a=2, b=40 → 0, because the result wraps modulo 2^32.
- Shifts:
  - SHR 12345678 by 9 → 24112.
  - SAR 0xFFFFFFFF by 9 → 0xFFFFFFFF.
  - SHL 42 by 9 → 21504.
  - SHL 1 by 40 → 0.
- Division by zero and illegal opcode:
  - DIV a=42, b=0 → 0xFFFFFFFF, `res_err`=1 at N+1.
  - MOD a=42, b=0 → 42, `res_err`=1.
  - Opcode 15 → 0, `res_err`=1.
- Back-pressure: DIV a=42, b=9 with `res_ready` held low for 10 cycles after `res_valid` rises.
  - Expect `res_data`=4 to be held.
  - Expect `op_ready`=0 throughout.
  - Expect a second `op_valid` in that window to be ignored.
- Reset mid-DIV: assert `rst_n`=0 at N+10.
  - Expect IDLE with all outputs at their reset values on the next cycle.
  - Expect no `res_valid` pulse.
  - A following ADD 1+1 returns 2 at its N+1.
